// File: rtl/nec_ir_decoder.sv
// NEC infrared frame decoder: measures mark/space runs on a tick time base,
// decodes 32-bit LSB-first frames and repeat codes, and strobes valid/repeat/error.
module nec_ir_decoder #(
  parameter int TICK_DIV   = 3516,
  parameter int UNIT_TICKS = 8,
  parameter bit MARK_LEVEL = 1'b0,
  parameter bit ADDR_CHECK = 1'b1,
  parameter bit REPEAT_EN  = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        signal,
  output logic [15:0] address,
  output logic [7:0]  command,
  output logic        valid,
  output logic        repeat_code,
  output logic        error,
  output logic        busy
);

  localparam int RW = $clog2(20 * UNIT_TICKS + 2);
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  localparam logic [RW-1:0] RUN_SAT    = RW'(20 * UNIT_TICKS + 1);
  localparam logic [RW-1:0] HALF_U     = RW'(UNIT_TICKS / 2);
  localparam logic [RW-1:0] TWO_U      = RW'(2 * UNIT_TICKS);
  localparam logic [RW-1:0] THREE_U    = RW'(3 * UNIT_TICKS);
  localparam logic [RW-1:0] FOUR_U     = RW'(4 * UNIT_TICKS);
  localparam logic [RW-1:0] FIVE_U     = RW'(5 * UNIT_TICKS);
  localparam logic [RW-1:0] SEVEN_U    = RW'(7 * UNIT_TICKS);
  localparam logic [RW-1:0] NINE_U     = RW'(9 * UNIT_TICKS);
  localparam logic [RW-1:0] FOURTEEN_U = RW'(14 * UNIT_TICKS);
  localparam logic [RW-1:0] EIGHTEEN_U = RW'(18 * UNIT_TICKS);
  localparam logic [PW-1:0] PRE_LAST   = PW'(TICK_DIV - 1);

  typedef enum logic [2:0] {
    IDLE,
    LEAD_MARK,
    LEAD_SPACE,
    BIT_MARK,
    BIT_SPACE,
    STOP_MARK,
    REP_STOP
  } state_t;

  state_t        state;
  logic          sync0, sync1, sync_d;
  logic          sig_edge, is_mark;
  logic [PW-1:0] pre_cnt;
  logic          tick;
  logic [RW-1:0] run_cnt, run_next;
  logic [4:0]    bit_cnt;
  logic [31:0]   frame;
  logic          seen;

  logic is_leader, is_frame_space, is_rep_space, is_bit_mark, is_zero, is_one;
  logic check_ok, fail, done_frame, done_rep;

  // Two-flop synchronizer plus one delay flop for edge detection.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync0  <= ~MARK_LEVEL;
      sync1  <= ~MARK_LEVEL;
      sync_d <= ~MARK_LEVEL;
    end else begin
      sync0  <= signal;
      sync1  <= sync0;
      sync_d <= sync1;
    end
  end

  assign sig_edge = sync1 ^ sync_d;
  assign is_mark  = (sync1 == MARK_LEVEL);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)     pre_cnt <= '0;
    else if (tick) pre_cnt <= '0;
    else           pre_cnt <= pre_cnt + 1'b1;
  end

  assign tick = (pre_cnt == PRE_LAST);

  // A tick coinciding with an edge is counted before the run is classified.
  assign run_next = (tick && run_cnt != RUN_SAT) ? run_cnt + 1'b1 : run_cnt;

  assign is_leader      = (run_next >= FOURTEEN_U) && (run_next <= EIGHTEEN_U);
  assign is_frame_space = (run_next >= SEVEN_U) && (run_next <= NINE_U);
  assign is_rep_space   = (run_next >= THREE_U) && (run_next < FIVE_U);
  assign is_bit_mark    = (run_next >= HALF_U) && (run_next < TWO_U);
  assign is_zero        = (run_next >= HALF_U) && (run_next < TWO_U);
  assign is_one         = (run_next >= TWO_U) && (run_next < FOUR_U);

  assign check_ok = (frame[31:24] == ~frame[23:16]) &&
                    (!ADDR_CHECK || (frame[15:8] == ~frame[7:0]));

  always_comb begin
    fail       = 1'b0;
    done_frame = 1'b0;
    done_rep   = 1'b0;
    if (state != IDLE) begin
      if (run_next == RUN_SAT) begin
        fail = 1'b1;
      end else if (sig_edge) begin
        case (state)
          LEAD_MARK:  fail = !is_leader;
          LEAD_SPACE: fail = !(is_frame_space || (REPEAT_EN && is_rep_space));
          BIT_MARK:   fail = !is_bit_mark;
          BIT_SPACE:  fail = !(is_zero || is_one);
          STOP_MARK: begin
            fail       = !(is_bit_mark && check_ok);
            done_frame = is_bit_mark && check_ok;
          end
          REP_STOP: begin
            fail     = !(is_bit_mark && seen);
            done_rep = is_bit_mark && seen;
          end
          default: fail = 1'b0;
        endcase
      end
    end
  end

  // Main FSM; also owns the run counter so it can be cleared on return to IDLE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      run_cnt     <= '0;
      bit_cnt     <= '0;
      frame       <= '0;
      seen        <= 1'b0;
      address     <= '0;
      command     <= '0;
      valid       <= 1'b0;
      repeat_code <= 1'b0;
      error       <= 1'b0;
      busy        <= 1'b0;
    end else begin
      valid       <= 1'b0;
      repeat_code <= 1'b0;
      error       <= 1'b0;
      run_cnt     <= sig_edge ? '0 : run_next;
      if (fail) begin
        error   <= 1'b1;
        seen    <= 1'b0;
        state   <= IDLE;
        busy    <= 1'b0;
        run_cnt <= '0;
      end else if (done_frame) begin
        valid   <= 1'b1;
        seen    <= 1'b1;
        command <= frame[23:16];
        address <= ADDR_CHECK ? {8'h00, frame[7:0]} : frame[15:0];
        state   <= IDLE;
        busy    <= 1'b0;
        run_cnt <= '0;
      end else if (done_rep) begin
        repeat_code <= 1'b1;
        state       <= IDLE;
        busy        <= 1'b0;
        run_cnt     <= '0;
      end else if (sig_edge) begin
        case (state)
          IDLE: begin
            if (is_mark) begin
              state <= LEAD_MARK;
              busy  <= 1'b1;
            end
          end
          LEAD_MARK: state <= LEAD_SPACE;
          LEAD_SPACE: begin
            if (is_frame_space) begin
              state   <= BIT_MARK;
              bit_cnt <= '0;
            end else begin
              state <= REP_STOP;
            end
          end
          BIT_MARK: state <= BIT_SPACE;
          BIT_SPACE: begin
            frame <= {is_one, frame[31:1]};
            if (bit_cnt == 5'd31) begin
              state <= STOP_MARK;
            end else begin
              bit_cnt <= bit_cnt + 5'd1;
              state   <= BIT_MARK;
            end
          end
          default: state <= state;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_nec_ir_decoder.sv
// Directed bench for nec_ir_decoder: one instance with address check, one with
// 16-bit extended address, sharing a waveform generator.
module tb_nec_ir_decoder;

  localparam int TICK_DIV   = 4;
  localparam int UNIT_TICKS = 8;
  localparam int U_CLK      = TICK_DIV * UNIT_TICKS;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic sig = 1'b1;
  logic use_b = 1'b0;
  logic sig_a, sig_b;

  logic [15:0] address_a, address_b;
  logic [7:0]  command_a, command_b;
  logic        valid_a, valid_b, rep_a, rep_b, error_a, error_b, busy_a, busy_b;

  int tests_run = 0;
  int tests_failed = 0;
  int n_valid_a = 0, n_rep_a = 0, n_err_a = 0;
  int n_valid_b = 0, n_rep_b = 0, n_err_b = 0;
  int excl_viol = 0;

  assign sig_a = use_b ? 1'b1 : sig;
  assign sig_b = use_b ? sig : 1'b1;

  always #5 clk = ~clk;

  nec_ir_decoder #(.TICK_DIV(TICK_DIV), .UNIT_TICKS(UNIT_TICKS), .MARK_LEVEL(1'b0),
                   .ADDR_CHECK(1'b1), .REPEAT_EN(1'b1)) dut_a (
    .clk(clk), .reset(reset), .signal(sig_a), .address(address_a), .command(command_a),
    .valid(valid_a), .repeat_code(rep_a), .error(error_a), .busy(busy_a));

  nec_ir_decoder #(.TICK_DIV(TICK_DIV), .UNIT_TICKS(UNIT_TICKS), .MARK_LEVEL(1'b0),
                   .ADDR_CHECK(1'b0), .REPEAT_EN(1'b1)) dut_b (
    .clk(clk), .reset(reset), .signal(sig_b), .address(address_b), .command(command_b),
    .valid(valid_b), .repeat_code(rep_b), .error(error_b), .busy(busy_b));

  // Strobe counters, sampled half a cycle away from the active edge.
  always @(negedge clk) begin
    if (valid_a) n_valid_a++;
    if (rep_a)   n_rep_a++;
    if (error_a) n_err_a++;
    if (valid_b) n_valid_b++;
    if (rep_b)   n_rep_b++;
    if (error_b) n_err_b++;
    if ((int'(valid_a) + int'(rep_a) + int'(error_a)) > 1) excl_viol++;
    if ((int'(valid_b) + int'(rep_b) + int'(error_b)) > 1) excl_viol++;
  end

  typedef struct {
    logic [31:0] frame;
    logic        on_b;
    logic        rep_after;
    int          d_valid;
    int          d_rep;
    int          d_err;
    logic [15:0] addr;
    logic [7:0]  cmd;
  } vec_t;

  vec_t vecs[5];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic level(input logic lvl, input int units);
    sig = lvl;
    repeat (units * U_CLK) @(negedge clk);
  endtask

  task automatic send_bits(input logic [31:0] f, input int n);
    for (int i = 0; i < n; i++) begin
      level(1'b0, 1);
      level(1'b1, f[i] ? 3 : 1);
    end
  endtask

  task automatic send_repeat();
    level(1'b0, 16);
    level(1'b1, 4);
    level(1'b0, 1);
    sig = 1'b1;
    repeat (20) @(negedge clk);
  endtask

  task automatic applyStimulus(input logic [31:0] f, input logic rep_after);
    level(1'b0, 16);
    level(1'b1, 8);
    send_bits(f, 32);
    level(1'b0, 1);
    sig = 1'b1;
    repeat (20) @(negedge clk);
    if (rep_after) send_repeat();
  endtask

  initial begin
    int pv, pr, pe, av, ar, ae;
    logic [15:0] act_addr;
    logic [7:0]  act_cmd;
    logic        act_busy;

    vecs[0] = '{32'hA55AFB04, 1'b0, 1'b1, 1, 1, 0, 16'h0004, 8'h5A};
    vecs[1] = '{32'h5A5AFB04, 1'b0, 1'b1, 0, 0, 2, 16'h0004, 8'h5A};
    vecs[2] = '{32'hEF101234, 1'b1, 1'b0, 1, 0, 0, 16'h1234, 8'h10};
    vecs[3] = '{32'hEF101234, 1'b0, 1'b0, 0, 0, 1, 16'h0004, 8'h5A};
    vecs[4] = '{32'hDF20FE01, 1'b0, 1'b1, 1, 1, 0, 16'h0001, 8'h20};

    repeat (3) @(negedge clk);
    checkOutput("rst_address", address_a, 16'h0000);
    checkOutput("rst_command", command_a, 8'h00);
    checkOutput("rst_valid", valid_a, 1'b0);
    checkOutput("rst_repeat", rep_a, 1'b0);
    checkOutput("rst_error", error_a, 1'b0);
    checkOutput("rst_busy", busy_a, 1'b0);
    reset = 1'b0;
    repeat (10) @(negedge clk);

    // Repeat code with no prior frame must be rejected.
    pr = n_rep_a; pe = n_err_a;
    send_repeat();
    checkOutput("rep_after_reset_err", n_err_a - pe, 1);
    checkOutput("rep_after_reset_rep", n_rep_a - pr, 0);

    for (int i = 0; i < 5; i++) begin
      use_b = vecs[i].on_b;
      pv = use_b ? n_valid_b : n_valid_a;
      pr = use_b ? n_rep_b : n_rep_a;
      pe = use_b ? n_err_b : n_err_a;
      applyStimulus(vecs[i].frame, vecs[i].rep_after);
      av       = use_b ? n_valid_b : n_valid_a;
      ar       = use_b ? n_rep_b : n_rep_a;
      ae       = use_b ? n_err_b : n_err_a;
      act_addr = use_b ? address_b : address_a;
      act_cmd  = use_b ? command_b : command_a;
      act_busy = use_b ? busy_b : busy_a;
      checkOutput($sformatf("vec%0d_valid", i), av - pv, vecs[i].d_valid);
      checkOutput($sformatf("vec%0d_repeat", i), ar - pr, vecs[i].d_rep);
      checkOutput($sformatf("vec%0d_error", i), ae - pe, vecs[i].d_err);
      checkOutput($sformatf("vec%0d_address", i), act_addr, vecs[i].addr);
      checkOutput($sformatf("vec%0d_command", i), act_cmd, vecs[i].cmd);
      checkOutput($sformatf("vec%0d_busy", i), act_busy, 1'b0);
    end
    use_b = 1'b0;

    // Line stuck at mark after the leader: the run counter saturates.
    pv = n_valid_a; pe = n_err_a;
    level(1'b0, 16);
    level(1'b1, 8);
    level(1'b0, 2);
    checkOutput("stuck_busy_mid", busy_a, 1'b1);
    level(1'b0, 23);
    checkOutput("stuck_error", n_err_a - pe, 1);
    checkOutput("stuck_valid", n_valid_a - pv, 0);
    checkOutput("stuck_busy_after", busy_a, 1'b0);
    sig = 1'b1;
    repeat (20) @(negedge clk);

    // Reset asserted during bit 10 of a frame.
    level(1'b0, 16);
    level(1'b1, 8);
    send_bits(32'hA55AFB04, 10);
    sig = 1'b0;
    repeat (16) @(negedge clk);
    checkOutput("midrst_busy_before", busy_a, 1'b1);
    pv = n_valid_a; pr = n_rep_a; pe = n_err_a;
    reset = 1'b1;
    sig = 1'b1;
    #1;
    checkOutput("midrst_address", address_a, 16'h0000);
    checkOutput("midrst_command", command_a, 8'h00);
    checkOutput("midrst_busy", busy_a, 1'b0);
    checkOutput("midrst_strobes", {valid_a, rep_a, error_a}, 3'b000);
    checkOutput("midrst_address_b", address_b, 16'h0000);
    repeat (4) @(negedge clk);
    reset = 1'b0;
    repeat (40) @(negedge clk);
    checkOutput("midrst_no_strobe", (n_valid_a - pv) + (n_rep_a - pr) + (n_err_a - pe), 0);

    pv = n_valid_a;
    applyStimulus(32'hA55AFB04, 1'b0);
    checkOutput("post_rst_valid", n_valid_a - pv, 1);
    checkOutput("post_rst_address", address_a, 16'h0004);
    checkOutput("post_rst_command", command_a, 8'h5A);

    checkOutput("strobe_exclusive", excl_viol, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
